// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared types and helpers for the TDM demultiplexer:
//               framing FSM state encoding and the slot-counter width function.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    // Framing FSM: HUNT waits for a frame marker, LOCK tracks slot position.
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_t;

    // Bits needed to count slots 0..n-1 (never less than one bit).
    function automatic int slot_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_ctr
// Description : Slot position counter for the TDM demultiplexer.
//               Priority of controls: clear-to-0, load-to-1, advance.
//               Advance wraps NUM_CH-1 -> 0 with an explicit compare, so
//               NUM_CH need not be a power of two.
// Ports       : clk      - clock, rising edge
//               rst_n    - asynchronous active-low reset
//               i_clr    - force slot to 0
//               i_load1  - force slot to 1
//               i_adv    - advance slot by one with wrap
//               o_slot   - current slot
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_ctr #(
    parameter int NUM_CH = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load1,
    input  logic              i_adv,
    output logic [SLOT_W-1:0] o_slot
);

    localparam logic [SLOT_W-1:0] c_last = SLOT_W'(NUM_CH - 1);
    localparam logic [SLOT_W-1:0] c_one  = SLOT_W'(1);

    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] w_slot_nxt;

    always_comb begin
        w_slot_nxt = r_slot;
        if (i_clr) begin
            w_slot_nxt = '0;
        end else if (i_load1) begin
            w_slot_nxt = c_one;
        end else if (i_adv) begin
            w_slot_nxt = (r_slot == c_last) ? '0 : r_slot + c_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    assign o_slot = r_slot;

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux
// Description : TDM receive demultiplexer. Accepts one sample per valid
//               cycle, tracks slot position against the frame marker and
//               steers each sample into its channel hold register. All
//               outputs are registered (1-cycle latency).
// Ports       : in_clk         - clock, rising edge
//               in_rst_n       - asynchronous active-low reset
//               in_data        - TDM sample
//               in_valid       - sample valid this cycle
//               in_frame       - slot-0 marker, qualified by in_valid
//               out_ch_data    - channel k in bits [k*DATA_W +: DATA_W]
//               out_ch_valid   - pulse: channel k updated
//               out_frame_done - pulse: last slot written
//               out_locked     - FSM is in LOCK
//               out_sync_err   - pulse: framing violation
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     in_frame,
    output logic [NUM_CH*DATA_W-1:0] out_ch_data,
    output logic [NUM_CH-1:0]        out_ch_valid,
    output logic                     out_frame_done,
    output logic                     out_locked,
    output logic                     out_sync_err
);

    localparam int                c_slot_w = slot_width(NUM_CH);
    localparam logic [c_slot_w-1:0] c_last = c_slot_w'(NUM_CH - 1);

    tdm_state_t          r_state;
    tdm_state_t          w_state_nxt;
    logic [c_slot_w-1:0] w_slot;

    logic                w_wr;
    logic [c_slot_w-1:0] w_wr_ch;
    logic                w_sync_err;
    logic                w_clr;
    logic                w_load1;
    logic                w_adv;
    logic [NUM_CH-1:0]   w_ch_valid;

    logic [NUM_CH-1:0]   r_ch_valid;
    logic                r_frame_done;
    logic                r_sync_err;

    // Framing decisions for the sample presented this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wr_ch     = '0;
        w_sync_err  = 1'b0;
        w_clr       = 1'b0;
        w_load1     = 1'b0;
        w_adv       = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    // Unframed samples are dropped until a marker shows up.
                    if (in_frame) begin
                        w_wr        = 1'b1;
                        w_load1     = 1'b1;
                        w_state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (in_frame) begin
                        // Marker always realigns to slot 0; flag it if early.
                        w_wr       = 1'b1;
                        w_load1    = 1'b1;
                        w_sync_err = (w_slot != '0);
                    end else if (w_slot == '0) begin
                        // Marker missing where one was due: lose lock.
                        w_sync_err  = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_wr    = 1'b1;
                        w_wr_ch = w_slot;
                        w_adv   = 1'b1;
                    end
                end
                default: begin
                    w_clr       = 1'b1;
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    always_comb begin
        w_ch_valid = '0;
        if (w_wr) begin
            w_ch_valid[w_wr_ch] = 1'b1;
        end
    end

    tdm_slot_ctr #(
        .NUM_CH (NUM_CH),
        .SLOT_W (c_slot_w)
    ) u_slot_ctr (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .i_clr   (w_clr),
        .i_load1 (w_load1),
        .i_adv   (w_adv),
        .o_slot  (w_slot)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state      <= HUNT;
            r_ch_valid   <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ch_valid   <= w_ch_valid;
            r_frame_done <= w_wr && (w_wr_ch == c_last);
            r_sync_err   <= w_sync_err;
        end
    end

    // Per-channel hold registers; only the addressed channel loads.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] r_hold;

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                r_hold <= '0;
            end else if (w_ch_valid[k]) begin
                r_hold <= in_data;
            end
        end

        assign out_ch_data[k*DATA_W +: DATA_W] = r_hold;
    end

    assign out_ch_valid   = r_ch_valid;
    assign out_frame_done = r_frame_done;
    assign out_sync_err   = r_sync_err;
    assign out_locked     = (r_state == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux
// Description : Self-checking bench for tdm_demux (NUM_CH=4, DATA_W=8).
//               Table of directed vectors plus a mid-cycle reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

    localparam int c_num_ch = 4;
    localparam int c_data_w = 8;

    typedef struct packed {
        logic        v;
        logic        f;
        logic [7:0]  d;
        logic [3:0]  cv;
        logic        fd;
        logic        lk;
        logic        se;
        logic [31:0] cd;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data;
    logic        valid;
    logic        frame;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic        frame_done;
    logic        locked;
    logic        sync_err;

    int   total;
    int   bad;
    vec_t tbl[$];

    tdm_demux #(
        .NUM_CH (c_num_ch),
        .DATA_W (c_data_w)
    ) dut (
        .in_clk         (clk),
        .in_rst_n       (rst_n),
        .in_data        (data),
        .in_valid       (valid),
        .in_frame       (frame),
        .out_ch_data    (ch_data),
        .out_ch_valid   (ch_valid),
        .out_frame_done (frame_done),
        .out_locked     (locked),
        .out_sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic f, input logic [7:0] d,
                                input logic [3:0] cv, input logic fd, input logic lk,
                                input logic se, input logic [31:0] cd);
        vec_t r;
        r.v = v; r.f = f; r.d = d; r.cv = cv;
        r.fd = fd; r.lk = lk; r.se = se; r.cd = cd;
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] cv, input logic fd,
                         input logic lk, input logic se, input logic [31:0] cd);
        total++;
        if (ch_valid !== cv || frame_done !== fd || locked !== lk ||
            sync_err !== se || ch_data !== cd) begin
            bad++;
            $display("FAIL %s: got cv=%b fd=%b lk=%b se=%b cd=%h, want cv=%b fd=%b lk=%b se=%b cd=%h",
                     name, ch_valid, frame_done, locked, sync_err, ch_data,
                     cv, fd, lk, se, cd);
        end
    endtask

    task automatic step(input logic v, input logic f, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        frame = f;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        valid = 1'b0;
        frame = 1'b0;
        data  = '0;

        // Scenario 1: back-to-back frames
        tbl.push_back(mk(1, 1, 8'h11, 4'b0001, 0, 1, 0, 32'h0000_0011));
        tbl.push_back(mk(1, 0, 8'h22, 4'b0010, 0, 1, 0, 32'h0000_2211));
        tbl.push_back(mk(1, 0, 8'h33, 4'b0100, 0, 1, 0, 32'h0033_2211));
        tbl.push_back(mk(1, 0, 8'h44, 4'b1000, 1, 1, 0, 32'h4433_2211));
        tbl.push_back(mk(1, 1, 8'h55, 4'b0001, 0, 1, 0, 32'h4433_2255));
        tbl.push_back(mk(1, 0, 8'h66, 4'b0010, 0, 1, 0, 32'h4433_6655));
        tbl.push_back(mk(1, 0, 8'h77, 4'b0100, 0, 1, 0, 32'h4477_6655));
        tbl.push_back(mk(1, 0, 8'h88, 4'b1000, 1, 1, 0, 32'h8877_6655));
        // Scenario 3: early marker at slot 2 realigns to ch0
        tbl.push_back(mk(1, 1, 8'h01, 4'b0001, 0, 1, 0, 32'h8877_6601));
        tbl.push_back(mk(1, 0, 8'h02, 4'b0010, 0, 1, 0, 32'h8877_0201));
        tbl.push_back(mk(1, 1, 8'hA5, 4'b0001, 0, 1, 1, 32'h8877_02A5));
        tbl.push_back(mk(1, 0, 8'hC3, 4'b0010, 0, 1, 0, 32'h8877_C3A5));
        // Scenario 4: missing marker at slot 0 drops lock
        tbl.push_back(mk(1, 0, 8'hD4, 4'b0100, 0, 1, 0, 32'h88D4_C3A5));
        tbl.push_back(mk(1, 0, 8'hE6, 4'b1000, 1, 1, 0, 32'hE6D4_C3A5));
        tbl.push_back(mk(1, 0, 8'hF0, 4'b0000, 0, 0, 1, 32'hE6D4_C3A5));
        // Scenario 2: unframed samples in HUNT, marker ignored without valid
        tbl.push_back(mk(1, 0, 8'h12, 4'b0000, 0, 0, 0, 32'hE6D4_C3A5));
        tbl.push_back(mk(0, 1, 8'h13, 4'b0000, 0, 0, 0, 32'hE6D4_C3A5));
        tbl.push_back(mk(1, 0, 8'h14, 4'b0000, 0, 0, 0, 32'hE6D4_C3A5));
        tbl.push_back(mk(1, 1, 8'h21, 4'b0001, 0, 1, 0, 32'hE6D4_C321));
        tbl.push_back(mk(1, 0, 8'h32, 4'b0010, 0, 1, 0, 32'hE6D4_3221));
        tbl.push_back(mk(1, 0, 8'h43, 4'b0100, 0, 1, 0, 32'hE643_3221));
        tbl.push_back(mk(1, 0, 8'h54, 4'b1000, 1, 1, 0, 32'h5443_3221));
        // Scenario 5: 3-cycle gaps between slots
        tbl.push_back(mk(1, 1, 8'h11, 4'b0001, 0, 1, 0, 32'h5443_3211));
        tbl.push_back(mk(0, 1, 8'h99, 4'b0000, 0, 1, 0, 32'h5443_3211));
        tbl.push_back(mk(0, 0, 8'h99, 4'b0000, 0, 1, 0, 32'h5443_3211));
        tbl.push_back(mk(0, 1, 8'h99, 4'b0000, 0, 1, 0, 32'h5443_3211));
        tbl.push_back(mk(1, 0, 8'h22, 4'b0010, 0, 1, 0, 32'h5443_2211));
        tbl.push_back(mk(0, 0, 8'hAA, 4'b0000, 0, 1, 0, 32'h5443_2211));
        tbl.push_back(mk(0, 1, 8'hAA, 4'b0000, 0, 1, 0, 32'h5443_2211));
        tbl.push_back(mk(0, 0, 8'hAA, 4'b0000, 0, 1, 0, 32'h5443_2211));
        tbl.push_back(mk(1, 0, 8'h33, 4'b0100, 0, 1, 0, 32'h5433_2211));
        tbl.push_back(mk(0, 0, 8'hBB, 4'b0000, 0, 1, 0, 32'h5433_2211));
        tbl.push_back(mk(0, 0, 8'hBB, 4'b0000, 0, 1, 0, 32'h5433_2211));
        tbl.push_back(mk(0, 1, 8'hBB, 4'b0000, 0, 1, 0, 32'h5433_2211));
        tbl.push_back(mk(1, 0, 8'h44, 4'b1000, 1, 1, 0, 32'h4433_2211));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].f, tbl[i].d);
            check($sformatf("vec%0d", i), tbl[i].cv, tbl[i].fd, tbl[i].lk,
                  tbl[i].se, tbl[i].cd);
        end

        // Scenario 6: asynchronous reset mid-frame at slot 2
        step(1, 1, 8'h5A);
        check("rst_pre0", 4'b0001, 0, 1, 0, 32'h4433_225A);
        step(1, 0, 8'h6B);
        check("rst_pre1", 4'b0010, 0, 1, 0, 32'h4433_6B5A);
        step(0, 0, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async", 4'b0000, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'h33);
        check("rst_hunt_drop", 4'b0000, 0, 0, 0, 32'h0);
        step(1, 1, 8'h77);
        check("rst_relock", 4'b0001, 0, 1, 0, 32'h0000_0077);
        step(1, 0, 8'h78);
        check("rst_next_ch1", 4'b0010, 0, 1, 0, 32'h0000_7877);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
